// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap sequencer for a 3-digit BCD seconds stopwatch.
// Conditions two raw pushbuttons, divides CLOCK_50 down to a 1 s count tick and
// sequences IDLE/RUN/PAUSE/DONE. Define STOPWATCH_LAP_EN to let a lap press in
// RUN freeze/unfreeze the displayed value while counting continues.
module stopwatch_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       start_btn_n,
  input  logic       lap_btn_n,
  input  logic       at_max_i,
  output logic       tick_o,
  output logic       clr_o,
  output logic       hold_o,
  output logic [1:0] state_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Bit 0 is the start button, bit 1 the lap button.
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         level_q, level_d;
  logic [1:0]         press_q, press_d;
  logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;

  logic start_ev, lap_ev;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          clr_q, clr_d;
  logic          hold_q, hold_d;
  logic          terminal;

  // Button registers: synchronizer chain, debounce counters, accepted levels and press pulses.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      sync1_q  <= 2'b11;
      sync2_q  <= 2'b11;
      level_q  <= 2'b11;
      press_q  <= 2'b00;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= {lap_btn_n, start_btn_n};
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Accept a level once it has differed from the accepted one for DEBOUNCE_CYC cycles; only presses raise an event.
  always_comb begin
    level_d  = level_q;
    press_d  = 2'b00;
    db_cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          press_d[i] = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // A simultaneous start press wins, so the lap event is dropped in that cycle.
  assign start_ev = press_q[0];
  assign lap_ev   = press_q[1] & ~press_q[0];
  assign terminal = (presc_q == PRESC_LAST);

  // Control state, prescaler and registered clear/hold outputs.
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q <= IDLE;
      presc_q <= '0;
      clr_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; reaching the terminal count with the counter at 999 ends the run instead of ticking.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr_d   = 1'b0;
    hold_d  = hold_q;
    tick_o  = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        hold_d  = 1'b0;
        if (start_ev) begin
          state_d = RUN;
        end else if (lap_ev) begin
          clr_d = 1'b1;
        end
      end
      RUN: begin
        presc_d = terminal ? '0 : presc_q + PW'(1);
        if (terminal && at_max_i) begin
          state_d = DONE;
        end else begin
          tick_o = terminal;
          if (start_ev) begin
            state_d = PAUSE;
          end
`ifdef STOPWATCH_LAP_EN
          else if (lap_ev) begin
            hold_d = ~hold_q;
          end
`endif
        end
      end
      PAUSE: begin
        if (start_ev) begin
          state_d = RUN;
        end else if (lap_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          hold_d  = 1'b0;
          presc_d = '0;
        end
      end
      DONE: begin
        presc_d = '0;
        if (lap_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
          hold_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_o = state_q;
  assign clr_o   = clr_q;
`ifdef STOPWATCH_LAP_EN
  assign hold_o  = hold_q;
`else
  assign hold_o  = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: bench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE_CYC=2.
// Expected outputs come from a behavioural model (sliding-window debounce over the
// raw sample history, run-time counted in elapsed RUN cycles), a constant vector
// table for the opening run, and hand-written corner-case sequences.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int DEBOUNCE_CYC = 2;
  localparam int HW           = DEBOUNCE_CYC + 2;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       KEY0;
  logic       start_btn_n;
  logic       lap_btn_n;
  logic       at_max_i;
  logic       tick_o;
  logic       clr_o;
  logic       hold_o;
  logic [1:0] state_o;

  stopwatch_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .KEY0       (KEY0),
    .start_btn_n(start_btn_n),
    .lap_btn_n  (lap_btn_n),
    .at_max_i   (at_max_i),
    .tick_o     (tick_o),
    .clr_o      (clr_o),
    .hold_o     (hold_o),
    .state_o    (state_o)
  );

  // Free-running 100 MHz-style clock, period 10 time units.
  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       start_n;
    logic       lap_n;
    logic       at_max;
    logic [1:0] exp_state;
    logic       exp_tick;
    logic       exp_clr;
    logic       exp_hold;
  } vec_t;

  vec_t vecs[21];
  vec_t cur_vec;
  bit   use_table = 1'b0;

  // Behavioural model state.
  bit            m_run, m_pause, m_done, m_hold, m_clr;
  int            m_cycles;
  bit            ev_s, ev_l, lvl_s, lvl_l;
  logic [HW-1:0] hist_s, hist_l;

  int ticks;
  bit s_raw, l_raw, m_rand;

  function automatic logic [1:0] m_state();
    return m_done ? 2'd3 : (m_pause ? 2'd2 : (m_run ? 2'd1 : 2'd0));
  endfunction

  function automatic int m_phase();
    return m_cycles % TICK_DIV;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pause = 0; m_done = 0; m_hold = 0; m_clr = 0;
    m_cycles = 0;
    ev_s = 0; ev_l = 0; lvl_s = 1; lvl_l = 1;
    hist_s = '1; hist_l = '1;
  endtask

  // A level is accepted when the DEBOUNCE_CYC synchronized samples before this edge
  // all differ from the accepted level; h[0] holds the newest raw sample.
  task automatic deb_model(input bit raw, input logic [HW-1:0] h_in, input bit lvl_in,
                           output logic [HW-1:0] h_out, output bit lvl_out, output bit ev);
    bit moved;
    moved = 1'b1;
    for (int i = 1; i <= DEBOUNCE_CYC; i++) begin
      if (h_in[i] == lvl_in) moved = 1'b0;
    end
    lvl_out = moved ? !lvl_in : lvl_in;
    ev      = moved && lvl_in;
    h_out   = {h_in[HW-2:0], raw};
  endtask

  // Advance the model by one clock edge using the events visible in the ending cycle.
  task automatic model_edge(input bit s, input bit l, input bit m);
    bit es, el, term;
    es    = ev_s;
    el    = ev_l && !ev_s;
    m_clr = 1'b0;
    if (m_run) begin
      term = (m_phase() == TICK_DIV - 1);
      m_cycles++;
      if (term && m) begin
        m_run = 0; m_done = 1;
      end else if (es) begin
        m_run = 0; m_pause = 1;
      end else if (el && LAP_EN) begin
        m_hold = !m_hold;
      end
    end else if (m_pause) begin
      if (es) begin
        m_pause = 0; m_run = 1;
      end else if (el) begin
        m_pause = 0; m_clr = 1; m_hold = 0; m_cycles = 0;
      end
    end else if (m_done) begin
      if (el) begin
        m_done = 0; m_clr = 1; m_hold = 0; m_cycles = 0;
      end
    end else begin
      if (es) begin
        m_run = 1; m_cycles = 0;
      end else if (el) begin
        m_clr = 1;
      end
    end
    deb_model(s, hist_s, lvl_s, hist_s, lvl_s, ev_s);
    deb_model(l, hist_l, lvl_l, hist_l, lvl_l, ev_l);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare this cycle's outputs, then cross the clock edge.
  task automatic applyStimulus(input bit s, input bit l, input bit m);
    start_btn_n = s;
    lap_btn_n   = l;
    at_max_i    = m;
    #1;
    checkOutput("model_state", int'(state_o), int'(m_state()));
    checkOutput("model_tick", int'(tick_o), int'(m_run && (m_phase() == TICK_DIV - 1) && !m));
    checkOutput("model_clr", int'(clr_o), int'(m_clr));
    checkOutput("model_hold", int'(hold_o), int'(m_hold));
    if (use_table) begin
      checkOutput("vec_state", int'(state_o), int'(cur_vec.exp_state));
      checkOutput("vec_tick", int'(tick_o), int'(cur_vec.exp_tick));
      checkOutput("vec_clr", int'(clr_o), int'(cur_vec.exp_clr));
      checkOutput("vec_hold", int'(hold_o), int'(cur_vec.exp_hold));
    end
    @(posedge CLOCK_50);
    model_edge(s, l, m);
    #1;
  endtask

  // Hold the chosen buttons for three cycles, release, and run through the event cycle.
  task automatic press(input bit do_s, input bit do_l, input bit m);
    repeat (3) applyStimulus(!do_s, !do_l, m);
    applyStimulus(1'b1, 1'b1, m);
    applyStimulus(1'b1, 1'b1, m);
  endtask

  task automatic idle(input int n, input bit m);
    repeat (n) applyStimulus(1'b1, 1'b1, m);
  endtask

  // Main sequence: reset, vector table, corner cases, then random traffic.
  initial begin
    vecs = '{
      '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0}
    };

    KEY0 = 1'b0; start_btn_n = 1'b1; lap_btn_n = 1'b1; at_max_i = 1'b0;
    model_reset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    checkOutput("reset_state", int'(state_o), 0);
    checkOutput("reset_tick", int'(tick_o), 0);
    checkOutput("reset_clr", int'(clr_o), 0);
    checkOutput("reset_hold", int'(hold_o), 0);
    KEY0 = 1'b1;

    // Start press from IDLE and 16 RUN cycles with a tick every 4th cycle.
    use_table = 1'b1;
    for (int i = 0; i < 21; i++) begin
      cur_vec = vecs[i];
      applyStimulus(vecs[i].start_n, vecs[i].lap_n, vecs[i].at_max);
    end
    use_table = 1'b0;

    // Pause one cycle before a tick; no ticks while paused; tick right after resume.
    for (int k = 0; k < TICK_DIV && m_phase() != 2; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    checkOutput("pause_state", int'(state_o), 2);
    for (int k = 0; k < 6; k++) begin
      checkOutput("pause_tick", int'(tick_o), 0);
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    press(1'b1, 1'b0, 1'b0);
    checkOutput("resume_state", int'(state_o), 1);
    checkOutput("resume_tick", int'(tick_o), 1);
    idle(3, 1'b0);

    // One-cycle glitch is ignored; a stable press causes exactly one transition.
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle(6, 1'b0);
    checkOutput("glitch_state", int'(state_o), 1);
    press(1'b1, 1'b0, 1'b0);
    checkOutput("single_press", int'(state_o), 2);
    idle(6, 1'b0);
    checkOutput("no_second_event", int'(state_o), 2);
    press(1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Counter at 999: terminal tick suppressed, DONE ignores start, lap clears.
    for (int k = 0; k < TICK_DIV && m_phase() != 2; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("atmax_tick", int'(tick_o), 0);
    checkOutput("atmax_run", int'(state_o), 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("done_state", int'(state_o), 3);
    press(1'b1, 1'b0, 1'b1);
    checkOutput("done_ignores_start", int'(state_o), 3);
    idle(3, 1'b1);
    press(1'b0, 1'b1, 1'b1);
    checkOutput("done_lap_clr", int'(clr_o), 1);
    checkOutput("done_lap_state", int'(state_o), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("clr_one_cycle", int'(clr_o), 0);
    idle(2, 1'b0);

    // Lap in RUN: hold toggles only with the lap feature, counting never stops.
    press(1'b1, 1'b0, 1'b0);
    checkOutput("restart_state", int'(state_o), 1);
    idle(3, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    checkOutput("lap_hold", int'(hold_o), int'(LAP_EN));
    checkOutput("lap_no_clr", int'(clr_o), 0);
    checkOutput("lap_state", int'(state_o), 1);
    ticks = 0;
    for (int k = 0; k < 8; k++) begin
      ticks += int'(tick_o);
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkOutput("ticks_while_hold", ticks, 2);
    press(1'b0, 1'b1, 1'b0);
    checkOutput("second_lap_hold", int'(hold_o), 0);
    checkOutput("second_lap_clr", int'(clr_o), 0);
    idle(3, 1'b0);

    // Simultaneous start and lap in PAUSE resume without a clear.
    press(1'b1, 1'b0, 1'b0);
    checkOutput("pause_again", int'(state_o), 2);
    idle(3, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    checkOutput("simul_state", int'(state_o), 1);
    checkOutput("simul_clr", int'(clr_o), 0);
    idle(3, 1'b0);

    // Reset asserted in a tick cycle aborts at once; start held through reset fires once.
    for (int k = 0; k < TICK_DIV && m_phase() != 3; k++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("pre_reset_tick", int'(tick_o), 1);
    KEY0 = 1'b0;
    start_btn_n = 1'b0;
    #1;
    checkOutput("abort_tick", int'(tick_o), 0);
    checkOutput("abort_state", int'(state_o), 0);
    checkOutput("abort_clr", int'(clr_o), 0);
    checkOutput("abort_hold", int'(hold_o), 0);
    @(posedge CLOCK_50);
    #1;
    checkOutput("abort_tick_next", int'(tick_o), 0);
    checkOutput("abort_state_next", int'(state_o), 0);
    model_reset();
    KEY0 = 1'b1;
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("held_reset_wait", int'(state_o), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("held_reset_event", int'(state_o), 1);
    idle(6, 1'b0);
    checkOutput("held_reset_single", int'(state_o), 1);

    // Random button activity, glitches and counter-full flags against the model.
    s_raw = 1'b1;
    l_raw = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) s_raw = !s_raw;
      if ($urandom_range(0, 5) == 0) l_raw = !l_raw;
      m_rand = ($urandom_range(0, 7) == 0);
      applyStimulus(s_raw, l_raw, m_rand);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
